ipml_rd_fifo_rr_scheduler: RTL and testbench
============================================

// Module: ipml_rd_fifo_rr_scheduler
// PURPOSE
//  Read-side scheduler for N prefetch FIFOs (rd_vld/rd_en/rd_data FWFT interface). Grants one channel at a
//  time in round-robin order and drains it in bursts of BURST_LEN beats onto a single registered output
//  stream tagged with a channel ID. Sits between the per-channel frame-read FIFOs and the video pipeline.
// PARAMETERS
//  N_CH       4    number of FIFO channels (2..8)
//  DATA_W     32   data width per channel
//  BURST_LEN  16   beats per grant (1..1024)
//  TIMEOUT    64   idle stall cycles inside a burst before forced release (>=1)
//  CH_W       $clog2(N_CH), CNT_W = $clog2(BURST_LEN+1), TO_W = $clog2(TIMEOUT+1) (localparams)
// PORTS
//  rd_clk        in   1             read clock
//  rd_rst        in   1             async reset, active high
//  ch_en         in   N_CH          per-channel enable for arbitration
//  fifo_rd_vld   in   N_CH          FIFO head valid (rd_vld of each FIFO)
//  fifo_rd_data  in   N_CH*DATA_W   FIFO head data, channel i at [i*DATA_W +: DATA_W]
//  fifo_rd_en    out  N_CH          pop strobe to each FIFO
//  out_data      out  DATA_W        output data (registered)
//  out_ch        out  CH_W          channel ID of out_data
//  out_vld       out  1             output valid
//  out_ready     in   1             downstream ready
//  out_last      out  1             last beat of a full burst
//  burst_abort   out  1             1-cycle pulse: burst released by timeout
//  busy          out  1             high while in BURST
// BEHAVIOUR
//  Reset (async on rd_rst, released to rd_clk): all outputs 0, state IDLE, rr pointer = N_CH-1 (ch0 first),
//   beat/timeout counters 0. Reset mid-burst drops the burst; no beat is popped in the reset cycle.
//  FSM states: IDLE, BURST, DRAIN.
//   IDLE: req = ch_en & fifo_rd_vld. If req != 0, grant the first set bit searching ptr+1, ptr+2 ... (mod
//    N_CH); latch grant g, ptr <= g, cnt <= 0, to_cnt <= 0, go BURST. No pop in IDLE. req==0: stay.
//   BURST: can_load = ~out_vld | out_ready. fifo_rd_en[g] = can_load & fifo_rd_vld[g]; other bits 0.
//    On pop: out_data <= fifo_rd_data[g], out_ch <= g, out_vld <= 1, cnt++, to_cnt <= 0,
//    out_last <= (cnt == BURST_LEN-1). Last pop -> DRAIN.
//    can_load & ~fifo_rd_vld[g]: to_cnt++; to_cnt == TIMEOUT-1 -> burst_abort pulse, go DRAIN.
//    Stall from out_ready low does not advance to_cnt.
//    ch_en[g] deasserting mid-burst does not stop the burst.
//   DRAIN: no pops; when output register empty or accepted (can_load) go IDLE. Min 1 idle cycle between bursts.
//  Output stage: out_vld cleared on out_ready & no new load; out_data/out_ch/out_last held stable while
//   out_vld & ~out_ready (AXI-stream style, no drop, no duplicate).
//  Latency: FIFO pop to out_vld = 1 cycle. Full throughput: 1 beat/cycle within a burst when out_ready=1.
//  Never more than one fifo_rd_en bit high; fifo_rd_en never high when fifo_rd_vld of that bit is low.
//  busy = (state == BURST). burst_abort and out_last are never high for the same burst.
// TESTING
//  1) All 4 ch enabled, FIFOs full, out_ready=1 -> bursts ch0,1,2,3,0; 16 beats each; out_last on beat 16;
//     1 idle cycle between bursts.
//  2) Only ch2 has data, ptr=2 after its burst -> ch2 re-granted next; ch0 data appears -> ch0 after ch2 burst.
//  3) ch1 FIFO empties after 5 beats, no refill -> 64 stall cycles, burst_abort pulse, out_last never set.
//  4) out_ready toggles 1/0 every cycle in burst -> data order/values match FIFO, no loss, no duplicate,
//     to_cnt stays 0.
//  5) Assert rd_rst at beat 7 of burst -> all outputs 0 next edge; after release ch0 granted first.
//  6) ch_en[3] cleared mid-burst of ch3 -> burst completes 16 beats; ch3 skipped afterwards.

Source files
------------

// File: rtl/ipml_rd_fifo_rr_scheduler_if.sv
// Bus bundle between the read-side scheduler and its environment.
//   ch_en, fifo_rd_vld, fifo_rd_data, out_ready : environment -> scheduler
//   fifo_rd_en, out_data, out_ch, out_vld,
//   out_last, burst_abort, busy                 : scheduler -> environment
// master = scheduler side, slave = FIFO bank / downstream side.
interface ipml_rd_fifo_rr_scheduler_if #(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CH_W   = $clog2(N_CH)
);
  logic [N_CH-1:0]        ch_en;
  logic [N_CH-1:0]        fifo_rd_vld;
  logic [N_CH*DATA_W-1:0] fifo_rd_data;
  logic [N_CH-1:0]        fifo_rd_en;
  logic [DATA_W-1:0]      out_data;
  logic [CH_W-1:0]        out_ch;
  logic                   out_vld;
  logic                   out_ready;
  logic                   out_last;
  logic                   burst_abort;
  logic                   busy;

  modport master (
    input  ch_en, fifo_rd_vld, fifo_rd_data, out_ready,
    output fifo_rd_en, out_data, out_ch, out_vld, out_last, burst_abort, busy
  );

  modport slave (
    output ch_en, fifo_rd_vld, fifo_rd_data, out_ready,
    input  fifo_rd_en, out_data, out_ch, out_vld, out_last, burst_abort, busy
  );
endinterface

// File: rtl/ipml_rd_fifo_rr_scheduler.sv
// Round-robin read scheduler for N_CH FWFT prefetch FIFOs. Grants one channel at a
// time, drains it in bursts of BURST_LEN beats into a single registered output
// stream tagged with the channel ID, and releases a burst early after TIMEOUT
// consecutive empty-FIFO cycles.
// Ports:
//   rd_clk  : read clock
//   rd_rst  : asynchronous reset, active high
//   bus     : scheduler side of ipml_rd_fifo_rr_scheduler_if
//             (fifo_rd_en is a same-cycle pop strobe; all out_* / burst_abort /
//              busy are registered)
module ipml_rd_fifo_rr_scheduler #(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BURST_LEN = 16,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic                             rd_clk,
  input  logic                             rd_rst,
  ipml_rd_fifo_rr_scheduler_if.master      bus
);

  localparam int unsigned CH_W  = $clog2(N_CH);
  localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [CH_W-1:0]   gnt_q, gnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TO_W-1:0]   to_q, to_d;

  logic [DATA_W-1:0] out_data_q;
  logic [CH_W-1:0]   out_ch_q;
  logic              out_vld_q;
  logic              out_last_q;
  logic              burst_abort_q;
  logic              busy_q;

  logic [N_CH-1:0]   req_c;
  logic [CH_W-1:0]   rr_sel_c;
  logic              rr_hit_c;
  logic [DATA_W-1:0] gnt_data_c;
  logic              can_load_c;
  logic              pop_c;
  logic              last_beat_c;
  logic              abort_c;

  assign req_c       = bus.ch_en & bus.fifo_rd_vld;
  // Output register can take a new beat when empty or being accepted this cycle.
  assign can_load_c  = ~out_vld_q | bus.out_ready;
  assign pop_c       = (state_q == BURST) & can_load_c & bus.fifo_rd_vld[gnt_q];
  assign last_beat_c = (cnt_q == CNT_W'(BURST_LEN - 1));

  // Round-robin pick: first requester after the last granted channel.
  always_comb begin
    logic [CH_W-1:0] idx;
    idx      = '0;
    rr_sel_c = '0;
    rr_hit_c = 1'b0;
    for (int unsigned i = 1; i <= N_CH; i++) begin
      idx = CH_W'((32'(ptr_q) + i) % N_CH);
      if (!rr_hit_c && req_c[idx]) begin
        rr_sel_c = idx;
        rr_hit_c = 1'b1;
      end
    end
  end

  // Head data of the granted channel.
  always_comb begin
    gnt_data_c = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (gnt_q == CH_W'(i)) gnt_data_c = bus.fifo_rd_data[i*DATA_W +: DATA_W];
    end
  end

  // Pop strobe: only the granted channel, only when its head is valid.
  always_comb begin
    bus.fifo_rd_en = '0;
    if (pop_c) bus.fifo_rd_en[gnt_q] = 1'b1;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    abort_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (rr_hit_c) begin
          gnt_d   = rr_sel_c;
          ptr_d   = rr_sel_c;
          cnt_d   = '0;
          to_d    = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        if (pop_c) begin
          cnt_d = cnt_q + CNT_W'(1);
          to_d  = '0;
          if (last_beat_c) state_d = DRAIN;
        end else if (can_load_c) begin
          // Only empty-FIFO cycles count towards the timeout; downstream stalls do not.
          if (to_q == TO_W'(TIMEOUT - 1)) begin
            abort_c = 1'b1;
            state_d = DRAIN;
          end else begin
            to_d = to_q + TO_W'(1);
          end
        end
      end
      DRAIN: begin
        if (can_load_c) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered output stage.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state_q       <= IDLE;
      ptr_q         <= CH_W'(N_CH - 1);
      gnt_q         <= '0;
      cnt_q         <= '0;
      to_q          <= '0;
      out_data_q    <= '0;
      out_ch_q      <= '0;
      out_vld_q     <= 1'b0;
      out_last_q    <= 1'b0;
      burst_abort_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      gnt_q         <= gnt_d;
      cnt_q         <= cnt_d;
      to_q          <= to_d;
      burst_abort_q <= abort_c;
      busy_q        <= (state_d == BURST);
      if (pop_c) begin
        out_data_q <= gnt_data_c;
        out_ch_q   <= gnt_q;
        out_vld_q  <= 1'b1;
        out_last_q <= last_beat_c;
      end else if (bus.out_ready) begin
        out_vld_q  <= 1'b0;
        out_last_q <= 1'b0;
      end
    end
  end

  assign bus.out_data    = out_data_q;
  assign bus.out_ch      = out_ch_q;
  assign bus.out_vld     = out_vld_q;
  assign bus.out_last    = out_last_q;
  assign bus.burst_abort = burst_abort_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_ipml_rd_fifo_rr_scheduler.sv
// Directed bench for ipml_rd_fifo_rr_scheduler. FIFOs are modelled as counters:
// channel i presents {8'(i), 24'(pop index)} while pop_cnt[i] < limit[i].
module tb_ipml_rd_fifo_rr_scheduler;

  localparam int unsigned N_CH      = 4;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned BURST_LEN = 16;
  localparam int unsigned TIMEOUT   = 64;
  localparam int unsigned CH_W      = 2;

  logic rd_clk = 1'b0;
  logic rd_rst;

  always #5 rd_clk = ~rd_clk;

  ipml_rd_fifo_rr_scheduler_if #(.N_CH(N_CH), .DATA_W(DATA_W)) bus ();

  ipml_rd_fifo_rr_scheduler #(
    .N_CH(N_CH), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .TIMEOUT(TIMEOUT)
  ) dut (
    .rd_clk(rd_clk),
    .rd_rst(rd_rst),
    .bus   (bus)
  );

  // FIFO model
  int unsigned pop_cnt [N_CH];
  int unsigned limit   [N_CH];

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      bus.fifo_rd_vld[i] = (pop_cnt[i] < limit[i]);
      bus.fifo_rd_data[i*DATA_W +: DATA_W] = {8'(i), 24'(pop_cnt[i])};
    end
  end

  always @(posedge rd_clk) begin
    for (int i = 0; i < N_CH; i++)
      if (bus.fifo_rd_en[i]) pop_cnt[i] <= pop_cnt[i] + 1;
  end

  int unsigned cyc;
  always @(posedge rd_clk) cyc <= cyc + 1;

  // Output monitor
  typedef struct {
    logic [CH_W-1:0]   ch;
    logic [DATA_W-1:0] data;
    logic              last;
    int unsigned       cyc;
  } beat_t;

  beat_t             q[$];
  int unsigned       abort_cnt;
  int unsigned       abort_cyc;
  int unsigned       viol_cnt;
  logic              prev_stall;
  logic [DATA_W-1:0] prev_data;
  logic [CH_W-1:0]   prev_ch;
  logic              prev_last;

  always @(negedge rd_clk) begin
    if (rd_rst !== 1'b0) begin
      prev_stall = 1'b0;
    end else begin
      if (bus.out_vld && bus.out_ready) begin
        beat_t b;
        b.ch = bus.out_ch; b.data = bus.out_data; b.last = bus.out_last; b.cyc = cyc;
        q.push_back(b);
      end
      if (bus.burst_abort) begin
        abort_cnt = abort_cnt + 1;
        abort_cyc = cyc;
      end
      if (!$onehot0(bus.fifo_rd_en) || ((bus.fifo_rd_en & ~bus.fifo_rd_vld) != '0))
        viol_cnt = viol_cnt + 1;
      if (prev_stall && (!bus.out_vld || bus.out_data !== prev_data ||
                         bus.out_ch !== prev_ch || bus.out_last !== prev_last))
        viol_cnt = viol_cnt + 1;
      prev_stall = bus.out_vld && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_ch    = bus.out_ch;
      prev_last  = bus.out_last;
    end
  end

  int unsigned n_assert;
  int unsigned n_fail;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_sync();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic wait_beats(input int unsigned n, input int unsigned budget, input string tag);
    int unsigned t;
    t = 0;
    while (q.size() < n && t < budget) begin
      @(negedge rd_clk);
      t++;
    end
    check({tag, " beat wait"}, 64'(q.size() >= n), 64'd1);
  endtask

  task automatic check_burst(input int unsigned qi, input int unsigned ch, input int unsigned base,
                             input int unsigned nb, input bit full, input bit thru, input string tag);
    for (int unsigned j = 0; j < nb; j++) begin
      if (qi + j < q.size()) begin
        beat_t b;
        b = q[qi + j];
        check($sformatf("%s ch b%0d", tag, j), 64'(b.ch), 64'(ch));
        check($sformatf("%s data b%0d", tag, j), 64'(b.data), 64'({8'(ch), 24'(base + j)}));
        check($sformatf("%s last b%0d", tag, j), 64'(b.last), 64'(full && (j == BURST_LEN - 1)));
        if (thru && j > 0)
          check($sformatf("%s gap b%0d", tag, j), 64'(b.cyc - q[qi + j - 1].cyc), 64'd1);
      end
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " out_vld"}, 64'(bus.out_vld), 64'd0);
    check({tag, " out_data"}, 64'(bus.out_data), 64'd0);
    check({tag, " out_ch"}, 64'(bus.out_ch), 64'd0);
    check({tag, " out_last"}, 64'(bus.out_last), 64'd0);
    check({tag, " burst_abort"}, 64'(bus.burst_abort), 64'd0);
    check({tag, " busy"}, 64'(bus.busy), 64'd0);
    check({tag, " fifo_rd_en"}, 64'(bus.fifo_rd_en), 64'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: sim time %0t exceeded, required finish before 1ms", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned qb, ab, pr;
    int unsigned b0, b1, b2, b3;
    int unsigned t;

    rd_rst        = 1'b1;
    bus.ch_en     = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < N_CH; i++) limit[i] = 0;

    repeat (3) @(negedge rd_clk);
    check_outputs_zero("reset");
    drive_sync();
    rd_rst = 1'b0;

    // 1) all channels full, ready high: bursts ch0,1,2,3,0
    drive_sync();
    limit[0] = 32; limit[1] = 16; limit[2] = 16; limit[3] = 16;
    bus.ch_en     = 4'hF;
    bus.out_ready = 1'b1;
    qb = q.size();
    wait_beats(qb + 80, 400, "t1");
    check_burst(qb,      0, 0,  16, 1'b1, 1'b1, "t1 b0");
    check_burst(qb + 16, 1, 0,  16, 1'b1, 1'b1, "t1 b1");
    check_burst(qb + 32, 2, 0,  16, 1'b1, 1'b1, "t1 b2");
    check_burst(qb + 48, 3, 0,  16, 1'b1, 1'b1, "t1 b3");
    check_burst(qb + 64, 0, 16, 16, 1'b1, 1'b1, "t1 b4");
    // Between bursts the FSM spends one DRAIN and one IDLE cycle without a pop.
    if (q.size() >= qb + 80) begin
      check("t1 burst gap", 64'(q[qb + 16].cyc - q[qb + 15].cyc), 64'd3);
      check("t1 burst gap2", 64'(q[qb + 64].cyc - q[qb + 63].cyc), 64'd3);
    end
    repeat (20) @(negedge rd_clk);
    check("t1 beat count", 64'(q.size()), 64'(qb + 80));
    check("t1 busy idle", 64'(bus.busy), 64'd0);

    // 2) only ch2 has data: re-granted; ch0 data during 2nd ch2 burst follows it
    drive_sync();
    qb = q.size();
    b2 = pop_cnt[2];
    limit[2] = b2 + 32;
    wait_beats(qb + 17, 200, "t2a");
    drive_sync();
    b0 = pop_cnt[0];
    limit[0] = b0 + 16;
    wait_beats(qb + 48, 300, "t2b");
    check_burst(qb,      2, b2,      16, 1'b1, 1'b1, "t2 b0");
    check_burst(qb + 16, 2, b2 + 16, 16, 1'b1, 1'b1, "t2 b1");
    check_burst(qb + 32, 0, b0,      16, 1'b1, 1'b1, "t2 b2");
    repeat (20) @(negedge rd_clk);
    check("t2 beat count", 64'(q.size()), 64'(qb + 48));

    // 3) ch1 empties after 5 beats: 64 stall cycles then a single abort pulse
    drive_sync();
    qb = q.size();
    ab = abort_cnt;
    b1 = pop_cnt[1];
    limit[1] = b1 + 5;
    wait_beats(qb + 5, 50, "t3");
    t = 0;
    while (abort_cnt == ab && t < 150) begin
      @(negedge rd_clk);
      t++;
    end
    check("t3 abort seen", 64'(abort_cnt), 64'(ab + 1));
    if (q.size() >= qb + 5)
      check("t3 abort timing", 64'(abort_cyc - q[qb + 4].cyc), 64'd64);
    check_burst(qb, 1, b1, 5, 1'b0, 1'b1, "t3");
    repeat (10) @(negedge rd_clk);
    check("t3 pulse width", 64'(abort_cnt), 64'(ab + 1));
    check("t3 beat count", 64'(q.size()), 64'(qb + 5));
    check("t3 busy idle", 64'(bus.busy), 64'd0);

    // 4) out_ready toggling every cycle: ordered, lossless, no duplicates
    drive_sync();
    qb = q.size();
    ab = abort_cnt;
    b3 = pop_cnt[3];
    limit[3] = b3 + 16;
    t = 0;
    while (q.size() < qb + 16 && t < 200) begin
      drive_sync();
      bus.out_ready = ~bus.out_ready;
      t++;
    end
    drive_sync();
    bus.out_ready = 1'b1;
    repeat (10) @(negedge rd_clk);
    check_burst(qb, 3, b3, 16, 1'b1, 1'b0, "t4");
    check("t4 beat count", 64'(q.size()), 64'(qb + 16));
    check("t4 no abort", 64'(abort_cnt), 64'(ab));

    // 5) reset at beat 7 of a ch1 burst; ch0 granted first afterwards
    drive_sync();
    qb = q.size();
    b1 = pop_cnt[1];
    limit[1] = b1 + 1000;
    wait_beats(qb + 7, 50, "t5a");
    check_burst(qb, 1, b1, 7, 1'b0, 1'b1, "t5 pre");
    drive_sync();
    rd_rst = 1'b1;
    pr = pop_cnt[1];
    limit[0] = pop_cnt[0] + 16;
    #1;
    check_outputs_zero("t5 reset");
    repeat (3) @(negedge rd_clk);
    check("t5 no pop in reset", 64'(pop_cnt[1]), 64'(pr));
    drive_sync();
    rd_rst = 1'b0;
    limit[1] = pop_cnt[1] + 16;
    b0 = pop_cnt[0];
    b1 = pop_cnt[1];
    qb = q.size();
    wait_beats(qb + 32, 200, "t5b");
    check_burst(qb,      0, b0, 16, 1'b1, 1'b1, "t5 b0");
    check_burst(qb + 16, 1, b1, 16, 1'b1, 1'b1, "t5 b1");

    // 6) ch_en[3] dropped mid-burst: burst completes, ch3 skipped afterwards
    repeat (10) @(negedge rd_clk);
    drive_sync();
    qb = q.size();
    b3 = pop_cnt[3];
    limit[3] = b3 + 32;
    wait_beats(qb + 4, 50, "t6a");
    drive_sync();
    bus.ch_en = 4'h7;
    b2 = pop_cnt[2];
    limit[2] = b2 + 16;
    wait_beats(qb + 32, 200, "t6b");
    repeat (40) @(negedge rd_clk);
    check_burst(qb,      3, b3, 16, 1'b1, 1'b1, "t6 b0");
    check_burst(qb + 16, 2, b2, 16, 1'b1, 1'b1, "t6 b1");
    check("t6 beat count", 64'(q.size()), 64'(qb + 32));
    check("t6 ch3 pops", 64'(pop_cnt[3]), 64'(b3 + 16));
    check("t6 busy idle", 64'(bus.busy), 64'd0);

    check("protocol violations", 64'(viol_cnt), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
